// File: rtl/duty_adjust.sv
// Duty-cycle word generator for the SWIPT output stage: tracks the requested duty,
// modulates it with the transmit bit stream during the data phase, clamps it and slew-limits it.
module duty_adjust #(
  parameter logic [11:0] DEFAULT_DUTY = 12'h0C8,
  parameter logic [11:0] MIN_DUTY     = 12'h032,
  parameter logic [11:0] MAX_DUTY     = 12'h1F4,
  parameter logic [11:0] MOD_DELTA    = 12'h014,
  parameter logic [11:0] SLEW_STEP    = 12'h00A
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [1:0]  prog,
  input  logic        read,
  input  logic        write,
  input  logic        data,
  input  logic [11:0] l,
  output logic [11:0] dutyCycle
);

  localparam logic [1:0] PROG_DATA = 2'b11;

  // Two guard bits keep l near full scale plus the offset from wrapping before the clamp.
  logic signed [13:0] l_ext;
  logic signed [13:0] delta_ext;
  logic signed [13:0] min_ext;
  logic signed [13:0] max_ext;
  logic signed [13:0] mod_sum;
  logic signed [13:0] target_wide;
  logic               modulate;
  logic [11:0]        target;

  always_comb begin
    l_ext     = signed'({2'b00, l});
    delta_ext = signed'({2'b00, MOD_DELTA});
    min_ext   = signed'({2'b00, MIN_DUTY});
    max_ext   = signed'({2'b00, MAX_DUTY});
    mod_sum   = data ? (l_ext + delta_ext) : (l_ext - delta_ext);
    // Receiving keeps the carrier clean, so read overrides write.
    modulate  = (prog == PROG_DATA) && write && !read;
    target_wide = modulate ? mod_sum : l_ext;
    if (target_wide < min_ext) begin
      target = MIN_DUTY;
    end else if (target_wide > max_ext) begin
      target = MAX_DUTY;
    end else begin
      target = target_wide[11:0];
    end
  end

  logic [11:0] up_gap;
  logic [11:0] down_gap;
  logic [11:0] duty_next;

  always_comb begin
    up_gap   = target - dutyCycle;
    down_gap = dutyCycle - target;
    duty_next = dutyCycle;
    if (target > dutyCycle) begin
      duty_next = dutyCycle + ((up_gap > SLEW_STEP) ? SLEW_STEP : up_gap);
    end else if (target < dutyCycle) begin
      duty_next = dutyCycle - ((down_gap > SLEW_STEP) ? SLEW_STEP : down_gap);
    end
  end

  // Losing the heartbeat snaps straight to the safe duty without slewing.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      dutyCycle <= DEFAULT_DUTY;
    end else if (!swiptAlive) begin
      dutyCycle <= DEFAULT_DUTY;
    end else begin
      dutyCycle <= duty_next;
    end
  end

endmodule

// File: tb/tb_duty_adjust.sv
// Self-checking bench for duty_adjust: directed scenarios plus randomized traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_duty_adjust;

  logic        clk = 1'b0;
  logic        nrst;
  logic        swiptAlive;
  logic [1:0]  prog;
  logic        read;
  logic        write;
  logic        data;
  logic [11:0] l;
  logic [11:0] dutyCycle;

  int checks   = 0;
  int failures = 0;
  int model_duty = 200;

  duty_adjust dut (
    .clk        (clk),
    .nrst       (nrst),
    .swiptAlive (swiptAlive),
    .prog       (prog),
    .read       (read),
    .write      (write),
    .data       (data),
    .l          (l),
    .dutyCycle  (dutyCycle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", tag, got, exp, $time);
    end
  endtask

  // Desired duty from the phase rules, in plain integers.
  function automatic int model_target();
    int t;
    t = int'(l);
    if (prog == 2'b11 && write && !read) t = data ? t + 20 : t - 20;
    if (t < 50)  t = 50;
    if (t > 500) t = 500;
    return t;
  endfunction

  // Advance one clock: update the model from the inputs held over the edge, then compare.
  task automatic step(input string tag);
    int d;
    @(posedge clk);
    if (nrst || !swiptAlive) begin
      model_duty = 200;
    end else begin
      d = model_target() - model_duty;
      if (d > 10)  d = 10;
      if (d < -10) d = -10;
      model_duty = model_duty + d;
    end
    #1;
    check(tag, dutyCycle, 12'(model_duty));
  endtask

  task automatic drive(input logic alive, input logic [1:0] p, input logic rd,
                       input logic wr, input logic dt, input logic [11:0] lv);
    swiptAlive = alive; prog = p; read = rd; write = wr; data = dt; l = lv;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);
    nrst = 1'b1;
    #2;
    check("reset_async", dutyCycle, 12'h0C8);
    step("reset_hold");
    @(negedge clk);
    nrst = 1'b0;

    // 1: nominal tracking at default
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'h0C8);
    run("idle_hold", 4);
    check("t1_hold", dutyCycle, 12'h0C8);

    // 2: modulation up then down
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 12'h0C8);
    step("t2_up1"); check("t2_d2", dutyCycle, 12'h0D2);
    step("t2_up2"); check("t2_dc", dutyCycle, 12'h0DC);
    run("t2_hold", 3); check("t2_hold_dc", dutyCycle, 12'h0DC);
    data = 1'b0;
    run("t2_down", 6); check("t2_b4", dutyCycle, 12'h0B4);

    // 3: clamps
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 12'h1F4);
    run("t3_hi", 45); check("t3_clamp_hi", dutyCycle, 12'h1F4);
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 12'h032);
    run("t3_lo", 50); check("t3_clamp_lo", dutyCycle, 12'h032);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'h000);
    run("t3_zero", 3); check("t3_l0_min", dutyCycle, 12'h032);

    // 4: read wins over write
    drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 12'h100);
    run("t4_read", 25); check("t4_unmod", dutyCycle, 12'h100);

    // 5: heartbeat loss and recovery
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'h1F4);
    run("t5_rise", 30); check("t5_top", dutyCycle, 12'h1F4);
    swiptAlive = 1'b0;
    step("t5_drop"); check("t5_default", dutyCycle, 12'h0C8);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'h0FA);
    step("t5_r1"); check("t5_d2", dutyCycle, 12'h0D2);
    step("t5_r2"); check("t5_dc", dutyCycle, 12'h0DC);
    step("t5_r3"); check("t5_e6", dutyCycle, 12'h0E6);
    step("t5_r4"); check("t5_f0", dutyCycle, 12'h0F0);
    step("t5_r5"); check("t5_fa", dutyCycle, 12'h0FA);

    // 6: no modulation outside data phase, then async reset mid-ramp
    drive(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 12'h150);
    run("t6_settle", 20); check("t6_150", dutyCycle, 12'h150);
    l = 12'h032;
    run("t6_ramp", 3);
    #2 nrst = 1'b1;
    #1 check("t6_async_rst", dutyCycle, 12'h0C8);
    model_duty = 200;
    @(negedge clk);
    nrst = 1'b0;

    // Randomized traffic, each setting held for a random bit period
    for (int seg = 0; seg < 300; seg++) begin
      int hold;
      logic [11:0] lv;
      case ($urandom_range(0, 3))
        0:       lv = 12'($urandom_range(0, 4095));
        1:       lv = 12'($urandom_range(0, 80));
        2:       lv = 12'($urandom_range(470, 560));
        default: lv = 12'($urandom_range(40, 520));
      endcase
      drive(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), lv);
      if ($urandom_range(0, 39) == 0) begin
        #2 nrst = 1'b1;
        #1 check("rand_async_rst", dutyCycle, 12'h0C8);
        model_duty = 200;
        @(negedge clk);
        nrst = 1'b0;
      end
      hold = $urandom_range(1, 12);
      run("rand", hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
